repeated_add_multiplier: RTL and testbench



---
 rtl/repeated_add_multiplier.sv | 95 +++++++++
 tb/tb_repeated_add_multiplier.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/repeated_add_multiplier.sv
// repeated_add_multiplier: unsigned sequential multiplier. The multiplicand and
// multiplier arrive one cycle apart on data_in; the product is built by adding
// the multiplicand into an accumulator once per unit of the multiplier while
// the multiplier counts down to zero.
//
// Handshake: start is a level request sampled only in IDLE. done is high for
// as long as the controller sits in DONE, and product is valid only then.
// DONE is left only when start is seen low, so every new operation needs
// start to fall and then rise again. Nothing but rst aborts a running
// operation.
module repeated_add_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] product,
  output logic             done,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_ACC    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_p;
  logic             r_done;
  logic             w_eqz;

  // Down-counter exhausted: accumulation is complete.
  assign w_eqz = (r_b == '0);

  // Controller and datapath in one block; done is registered so that it is
  // high exactly while the state is DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_p     <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_LOAD_A;
          end
        end
        S_LOAD_A: begin
          r_a     <= data_in;
          r_state <= S_LOAD_B;
        end
        S_LOAD_B: begin
          r_b     <= data_in;
          r_p     <= '0;
          r_state <= S_ACC;
        end
        S_ACC: begin
          if (!w_eqz) begin
            // Wraps modulo 2^WIDTH; overflow is silently discarded.
            r_p <= r_p + r_a;
            r_b <= r_b - 1'b1;
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          if (!start) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign product   = r_p;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_repeated_add_multiplier.sv
// tb_repeated_add_multiplier: directed and random operations checked against
// a plain-arithmetic model (product = a*b mod 2^W, done after b+3 edges).
module tb_repeated_add_multiplier;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] data_in;
  logic [W-1:0] product;
  logic         done;
  logic [2:0]   dbg_state;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  repeated_add_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .product   (product),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives start and both operands; returns just after the edge that
  // captured B (two edges after start was sampled).
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
    logic [2*W-1:0] full;
    start   = 1'b1;
    data_in = W'($urandom);
    tick();                                   // e0: start sampled
    start   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    data_in = a;
    tick();                                   // e1: A captured
    start   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    data_in = b;
    tick();                                   // e2: B captured, P cleared
    check("done_low_in_acc", {31'd0, done}, 32'd0);
    full = a * b;
    exp_q.push_back(full[W-1:0]);
  endtask

  // Waits for done (bounded), checks latency and product, holds start high
  // through DONE, then drops start for one cycle.
  task automatic finish_op(input logic [W-1:0] b, input bit noise);
    int n;
    logic [W-1:0] exp;
    n = 2;
    while (!done && n < int'(b) + 10) begin
      if (noise) begin
        start   = 1'($urandom_range(0, 1));
        data_in = W'($urandom);
      end
      tick();
      n++;
    end
    check("latency", n, int'(b) + 3);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("product", {16'd0, product}, {16'd0, exp});
    start = 1'b1;
    repeat (2) begin
      tick();
      check("done_hold", {31'd0, done}, 32'd1);
      check("product_hold", {16'd0, product}, {16'd0, exp});
    end
    start = 1'b0;
    tick();
    check("done_fall", {31'd0, done}, 32'd0);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
    start_op(a, b, noise);
    finish_op(b, noise);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    repeat (2) tick();
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_product", {16'd0, product}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_done", {31'd0, done}, 32'd0);

    run_op(16'd5, 16'd6, 1'b0);       // basic: 30
    run_op(16'd7, 16'd0, 1'b0);       // zero multiplier
    run_op(16'd0, 16'd4, 1'b0);       // zero multiplicand
    run_op(16'd300, 16'd300, 1'b0);   // wraps to 24464

    // reset during the third accumulate cycle
    start_op(16'd9, 16'd10, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_product", {16'd0, product}, 32'd0);
    check("midrst_state_idle", {29'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    tick();
    run_op(16'd3, 16'd4, 1'b0);       // 12

    run_op(16'd2, 16'd3, 1'b0);       // after handshake: 6
    run_op(16'd4, 16'd5, 1'b1);       // noise on start/data_in: 20

    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = W'($urandom_range(0, 40));
      run_op(ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
